// File: rtl/mips_prog_loader.sv
// Boot-time program loader: parses a framed byte stream (SYNC, ADDR, COUNT, data, CHECKSUM)
// into big-endian words, writes them to core memory and releases the MIPS32 core from hold.
module mips_prog_loader #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned TIMEOUT = 1024,
   parameter logic [7:0]  SYNC    = 8'hA5
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              reload,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              cpu_start,
   output logic              busy,
   output logic              err_checksum,
   output logic              err_timeout,
   output logic [15:0]       words_loaded
);

   localparam int unsigned       TO_W    = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_CNT, S_DATA, S_CHK, S_RUN, S_ERR
   } state_t;

   state_t            state, state_nx;
   logic [1:0]        bidx;
   logic [23:0]       byte_sr;
   logic [ADDR_W-1:0] ptr;
   logic [15:0]       rem;
   logic [31:0]       csum;
   logic [TO_W-1:0]   to_cnt;
   logic              accept, word_done, to_hit, parked;
   logic [31:0]       word;

   assign in_ready  = (state != S_RUN) && (state != S_ERR);
   assign busy      = state inside {S_ADDR, S_CNT, S_DATA, S_CHK};
   assign cpu_hold  = (state != S_RUN);
   assign parked    = (state == S_RUN) || (state == S_ERR);
   assign accept    = in_valid && in_ready;
   assign word      = {byte_sr, in_data};
   assign word_done = accept && busy && (bidx == 2'd3);
   // An accepted byte on the expiry edge wins over the timeout.
   assign to_hit    = busy && !accept && (to_cnt == TO_LAST);

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (accept && in_data == SYNC) state_nx = S_ADDR;
         S_ADDR:  if (word_done) state_nx = S_CNT;
         S_CNT:   if (word_done) state_nx = (word[15:0] == 16'd0) ? S_CHK : S_DATA;
         S_DATA:  if (word_done && rem == 16'd1) state_nx = S_CHK;
         S_CHK:   if (word_done) state_nx = (word == csum) ? S_RUN : S_ERR;
         S_RUN,
         S_ERR:   if (reload) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      if (to_hit) state_nx = S_ERR;
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         cpu_start    <= 1'b0;
         err_checksum <= 1'b0;
         err_timeout  <= 1'b0;
         words_loaded <= '0;
         bidx         <= '0;
         byte_sr      <= '0;
         ptr          <= '0;
         rem          <= '0;
         csum         <= '0;
         to_cnt       <= '0;
      end else begin
         mem_we    <= 1'b0;
         cpu_start <= 1'b0;

         if (busy && !accept) to_cnt <= to_cnt + TO_W'(1);
         else                 to_cnt <= '0;

         // Timeout drops any partially assembled word.
         if (to_hit) begin
            bidx        <= '0;
            err_timeout <= 1'b1;
         end else if (accept && busy) begin
            bidx    <= bidx + 2'd1;
            byte_sr <= {byte_sr[15:0], in_data};
         end

         if (word_done) begin
            if (state == S_ADDR) begin
               ptr <= word[ADDR_W-1:0];
            end else if (state == S_CNT) begin
               rem  <= word[15:0];
               csum <= '0;
            end else if (state == S_DATA) begin
               mem_we       <= 1'b1;
               mem_addr     <= ptr;
               mem_wdata    <= word;
               ptr          <= ptr + ADDR_W'(1);
               csum         <= csum ^ word;
               rem          <= rem - 16'd1;
               words_loaded <= words_loaded + 16'd1;
            end else if (state == S_CHK) begin
               if (word == csum) cpu_start    <= 1'b1;
               else              err_checksum <= 1'b1;
            end
         end

         if (parked && reload) begin
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            words_loaded <= '0;
         end
      end
   end

endmodule
